// File: rtl/lsq_port_arbiter.sv
// Purpose : arbitrates one memory port between the load pipe and the store-queue head, with store anti-starvation and fence drain.
// Latency : grants (load_ready / sq_pop) are combinational; the granted request appears on mem_* one edge later.
// Backpressure: a new grant is made only when the output slot is free (~mem_valid | mem_ready); mem_* hold while mem_valid & ~mem_ready.
//
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   load_valid/addr/fn3, load_ready   load request channel, load_ready = accepted this cycle
//   store_conflict                load blocked behind an older unissued store
//   sq_valid/addr/be/data/fn3     store-queue head entry (released, aligned)
//   sq_full, sq_empty             store-queue occupancy flags
//   sq_pop                        head store consumed this cycle
//   drain_req, drain_done         fence: drain all stores, one-cycle completion pulse
//   mem_valid/ready/rnw/addr/be/data/fn3   registered single memory port (rnw=1 for loads)
module lsq_port_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        load_valid,
    input  logic [31:0] load_addr,
    input  logic [2:0]  load_fn3,
    output logic        load_ready,
    input  logic        store_conflict,

    input  logic        sq_valid,
    input  logic [31:0] sq_addr,
    input  logic [3:0]  sq_be,
    input  logic [31:0] sq_data,
    input  logic [2:0]  sq_fn3,
    input  logic        sq_full,
    input  logic        sq_empty,
    output logic        sq_pop,

    input  logic        drain_req,
    output logic        drain_done,

    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_rnw,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_data,
    output logic [2:0]  mem_fn3
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        DRAIN  = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Registered memory request as one packed bus.
    typedef struct packed {
        logic        rnw;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [2:0]  fn3;
    } mem_req_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic             mem_vld_q;
    mem_req_t         mem_q;

    logic slot_free;
    logic load_eligible;
    logic starve_hit;
    logic store_grant;
    logic load_grant;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // Stores win whenever loads cannot go, the queue is full, the load
    // streak has hit the starvation limit, or a fence is draining. The
    // rst term keeps both handshakes low while reset is held, since the
    // grants are combinational and would otherwise follow the inputs.
    always_comb begin
        slot_free     = ~mem_vld_q | mem_ready;
        load_eligible = load_valid & ~store_conflict & ~drain_req & (state == NORMAL);
        starve_hit    = (starve_cnt == LIMIT);
        store_grant   = ~rst & slot_free & sq_valid &
                        (~load_eligible | sq_full | starve_hit | (state == DRAIN));
        load_grant    = ~rst & slot_free & load_eligible & ~store_grant;
    end

    assign load_ready = load_grant;
    assign sq_pop     = store_grant;

    // ------------------------------------------------------------------
    // Load-streak counter: counts loads granted past a waiting store.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (store_grant || !sq_valid) begin
            starve_cnt <= '0;
        end else if (load_grant && !starve_hit) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Fence FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= NORMAL;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN waits for the queue to be empty and the output register to
    // have handed off its last store, so an in-flight store completes
    // before the completion pulse.
    always_comb begin
        state_next = state;
        case (state)
            NORMAL:  if (drain_req) state_next = DRAIN;
            DRAIN:   if (sq_empty && !sq_valid && !mem_vld_q) state_next = DONE;
            DONE:    state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    assign drain_done = (state == DONE);

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_vld_q <= 1'b0;
            mem_q     <= '0;
        end else if (load_grant) begin
            mem_vld_q  <= 1'b1;
            mem_q.rnw  <= 1'b1;
            mem_q.addr <= load_addr;
            mem_q.be   <= 4'hF;
            mem_q.data <= 32'h0;
            mem_q.fn3  <= load_fn3;
        end else if (store_grant) begin
            mem_vld_q  <= 1'b1;
            mem_q.rnw  <= 1'b0;
            mem_q.addr <= sq_addr;
            mem_q.be   <= sq_be;
            mem_q.data <= sq_data;
            mem_q.fn3  <= sq_fn3;
        end else if (mem_ready) begin
            // Handshake done with nothing new: drop valid, keep payload.
            mem_vld_q <= 1'b0;
        end
    end

    assign mem_valid = mem_vld_q;
    assign mem_rnw   = mem_q.rnw;
    assign mem_addr  = mem_q.addr;
    assign mem_be    = mem_q.be;
    assign mem_data  = mem_q.data;
    assign mem_fn3   = mem_q.fn3;

    // Only one requester may own the port in a cycle.
    grant_onehot: assert property (@(posedge clk) disable iff (rst)
        !(load_grant && store_grant));

endmodule
